// File: rtl/ysyx_24080006_mdu_iter.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide,
// retiring STEP bits per cycle on operand magnitudes with a final sign fix-up.
module ysyx_24080006_mdu_iter #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned STEP = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic            signed_a,
    input  logic            signed_b,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int unsigned NITER = XLEN / STEP;
    localparam int unsigned CW    = $clog2(NITER);
    localparam int unsigned DW    = 2 * XLEN;

    localparam logic [1:0] OP_MULL = 2'd0;
    localparam logic [1:0] OP_MULH = 2'd1;
    localparam logic [1:0] OP_DIV  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic            fin_q;
    logic            spec_q;
    logic [1:0]      op_q;
    logic            neg_q;
    logic            rneg_q;
    logic [XLEN-1:0] opb_q;
    logic [DW-1:0]   acc_q;

    // Request-side decode: sign handling, magnitudes and the shortcut cases
    logic            is_div_c;
    logic            a_neg_c;
    logic            b_neg_c;
    logic            div0_c;
    logic            ovf_c;
    logic            accept_c;
    logic [XLEN-1:0] a_mag_c;
    logic [XLEN-1:0] b_mag_c;
    logic [XLEN-1:0] spec_res_c;

    assign is_div_c   = op[1];
    assign a_neg_c    = signed_a & a[XLEN-1];
    assign b_neg_c    = (is_div_c ? signed_a : signed_b) & b[XLEN-1];
    assign a_mag_c    = a_neg_c ? (~a + XLEN'(1)) : a;
    assign b_mag_c    = b_neg_c ? (~b + XLEN'(1)) : b;
    assign div0_c     = is_div_c && (b == '0);
    assign ovf_c      = is_div_c && signed_a && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    assign spec_res_c = div0_c ? ((op == OP_DIV) ? '1 : a)
                               : ((op == OP_DIV) ? a  : '0);
    assign accept_c   = in_valid && in_ready && !flush;

    // One iteration: STEP shift-add (multiply) or restoring (divide) sub-steps
    logic [DW-1:0]   acc_step_c;
    logic [XLEN:0]   rem_sh_c;
    logic [XLEN-1:0] quo_sh_c;
    logic [XLEN:0]   hi_sum_c;

    always_comb begin
        acc_step_c = acc_q;
        rem_sh_c   = '0;
        quo_sh_c   = '0;
        hi_sum_c   = '0;
        for (int unsigned i = 0; i < STEP; i++) begin
            if (op_q[1]) begin
                rem_sh_c = {acc_step_c[DW-1:XLEN], acc_step_c[XLEN-1]};
                quo_sh_c = {acc_step_c[XLEN-2:0], 1'b0};
                if (rem_sh_c >= {1'b0, opb_q}) begin
                    rem_sh_c    = rem_sh_c - {1'b0, opb_q};
                    quo_sh_c[0] = 1'b1;
                end
                acc_step_c = {rem_sh_c[XLEN-1:0], quo_sh_c};
            end else begin
                hi_sum_c   = {1'b0, acc_step_c[DW-1:XLEN]}
                           + (acc_step_c[0] ? {1'b0, opb_q} : '0);
                acc_step_c = {hi_sum_c, acc_step_c[XLEN-1:1]};
            end
        end
    end

    // Sign fix-up and result selection once all bits are retired
    logic [DW-1:0]   prod_c;
    logic [XLEN-1:0] quo_c;
    logic [XLEN-1:0] rem_c;
    logic [XLEN-1:0] final_c;

    assign prod_c = neg_q  ? (~acc_q + DW'(1)) : acc_q;
    assign quo_c  = neg_q  ? (~acc_q[XLEN-1:0] + XLEN'(1)) : acc_q[XLEN-1:0];
    assign rem_c  = rneg_q ? (~acc_q[DW-1:XLEN] + XLEN'(1)) : acc_q[DW-1:XLEN];

    always_comb begin
        final_c = '0;
        unique case (op_q)
            OP_MULL: final_c = prod_c[XLEN-1:0];
            OP_MULH: final_c = prod_c[DW-1:XLEN];
            OP_DIV:  final_c = quo_c;
            default: final_c = rem_c;
        endcase
        if (spec_q) begin
            final_c = acc_q[XLEN-1:0];
        end
    end

    // Control FSM with registered handshake outputs and result
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            fin_q     <= 1'b0;
            spec_q    <= 1'b0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            opb_q     <= '0;
            acc_q     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
        end else if (flush) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            fin_q     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept_c) begin
                        state_q  <= CALC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        op_q     <= op;
                        neg_q    <= a_neg_c ^ b_neg_c;
                        rneg_q   <= a_neg_c;
                        opb_q    <= b_mag_c;
                        cnt_q    <= CW'(NITER - 1);
                        // Shortcut cases go straight to the fix-up cycle
                        spec_q   <= div0_c || ovf_c;
                        fin_q    <= div0_c || ovf_c;
                        acc_q    <= {{XLEN{1'b0}}, (div0_c || ovf_c) ? spec_res_c : a_mag_c};
                    end
                end
                CALC: begin
                    if (fin_q) begin
                        state_q   <= DONE;
                        fin_q     <= 1'b0;
                        out_valid <= 1'b1;
                        result    <= final_c;
                    end else begin
                        acc_q <= acc_step_c;
                        if (cnt_q == '0) begin
                            fin_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q   <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        result    <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24080006_mdu_iter.sv
// Self-checking bench for ysyx_24080006_mdu_iter (XLEN=32, STEP=2).
module tb_ysyx_24080006_mdu_iter;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic        signed_a;
    logic        signed_b;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    ysyx_24080006_mdu_iter #(.XLEN(32), .STEP(2)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .signed_a  (signed_a),
        .signed_b  (signed_b),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [1:0]  op;
        logic        sa;
        logic        sb;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        int          stall;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model built on native wide arithmetic
    function automatic logic [31:0] ref_res(input logic [1:0] o, input logic sa, input logic sb,
                                            input logic [31:0] x, input logic [31:0] y);
        logic [63:0] ax;
        logic [63:0] by;
        logic [63:0] p;
        ax = sa ? {{32{x[31]}}, x} : {32'h0, x};
        by = sb ? {{32{y[31]}}, y} : {32'h0, y};
        p  = ax * by;
        if (o == 2'd0) return p[31:0];
        if (o == 2'd1) return p[63:32];
        if (y == 32'h0) return (o == 2'd2) ? 32'hFFFF_FFFF : x;
        if (sa && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return (o == 2'd2) ? x : 32'h0;
        if (sa) return (o == 2'd2) ? 32'($signed(x) / $signed(y)) : 32'($signed(x) % $signed(y));
        return (o == 2'd2) ? (x / y) : (x % y);
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic sa,
                                   input logic [31:0] x, input logic [31:0] y);
        if (o[1] && (y == 32'h0 || (sa && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 1;
        return 17;
    endfunction

    task automatic start_op(input logic [1:0] o, input logic sa, input logic sb,
                            input logic [31:0] x, input logic [31:0] y);
        op = o; signed_a = sa; signed_b = sb; a = x; b = y; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        op = 2'($urandom); signed_a = 1'($urandom); signed_b = 1'($urandom);
        a = $urandom; b = $urandom;
    endtask

    task automatic run_op(input vec_t v, input string nm);
        int   w;
        int   lat;
        logic zero_ok;
        logic stable_ok;
        logic [31:0] held;
        w = 0;
        while (!in_ready && w < 40) begin tick(); w++; end
        chk({nm, "_ready"}, 64'(in_ready), 64'd1);
        start_op(v.op, v.sa, v.sb, v.a, v.b);
        lat = 0;
        zero_ok = 1'b1;
        while (!out_valid && lat < 40) begin
            if (result != 32'h0) zero_ok = 1'b0;
            tick();
            lat++;
        end
        chk({nm, "_lat"}, 64'(lat), 64'(v.lat));
        chk({nm, "_res"}, 64'(result), 64'(v.exp));
        chk({nm, "_zero"}, 64'(zero_ok), 64'd1);
        held = result;
        stable_ok = 1'b1;
        for (int i = 0; i < v.stall; i++) begin
            tick();
            if (!out_valid || result !== held || in_ready || !busy) stable_ok = 1'b0;
        end
        if (v.stall > 0) chk({nm, "_stall"}, 64'(stable_ok), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({nm, "_idle"}, 64'({out_valid, busy, in_ready, result}), 64'({3'b001, 32'h0}));
    endtask

    vec_t vecs[$];

    initial begin
        logic sticky;
        vec_t rv;
        vecs.push_back('{2'd0, 1'b1, 1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 17, 0});
        vecs.push_back('{2'd1, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 17, 0});
        vecs.push_back('{2'd1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 17, 3});
        vecs.push_back('{2'd1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 17, 0});
        vecs.push_back('{2'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 17, 0});
        vecs.push_back('{2'd0, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 17, 0});
        vecs.push_back('{2'd1, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 17, 0});
        vecs.push_back('{2'd2, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 17, 0});
        vecs.push_back('{2'd3, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 17, 2});
        vecs.push_back('{2'd2, 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 17, 0});
        vecs.push_back('{2'd3, 1'b0, 1'b0, 32'd100, 32'd7, 32'd2, 17, 0});
        vecs.push_back('{2'd2, 1'b0, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0});
        vecs.push_back('{2'd3, 1'b0, 1'b0, 32'd5, 32'd0, 32'd5, 1, 3});
        vecs.push_back('{2'd2, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0});
        vecs.push_back('{2'd3, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0});
        vecs.push_back('{2'd2, 1'b1, 1'b0, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 17, 0});
        vecs.push_back('{2'd3, 1'b1, 1'b0, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 17, 0});
        vecs.push_back('{2'd2, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 17, 0});
        vecs.push_back('{2'd2, 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 17, 0});
        vecs.push_back('{2'd3, 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 17, 0});

        reset_n = 1'b0; in_valid = 1'b0; op = 2'd0; signed_a = 1'b0; signed_b = 1'b0;
        a = 32'h0; b = 32'h0; flush = 1'b0; out_ready = 1'b0;
        #3;
        chk("reset_outs", 64'({in_ready, out_valid, busy, result}), 64'd0);
        tick(); tick();
        chk("reset_held", 64'({in_ready, out_valid, busy, result}), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        chk("ready_after_reset", 64'({in_ready, busy}), 64'b10);

        foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

        // Flush in the fifth CALC cycle abandons the multiply
        start_op(2'd0, 1'b0, 1'b0, 32'd123, 32'd456);
        for (int i = 0; i < 4; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_calc", 64'({in_ready, out_valid, busy, result}), 64'({3'b100, 32'h0}));
        sticky = 1'b0;
        for (int i = 0; i < 20; i++) begin tick(); if (out_valid || busy) sticky = 1'b1; end
        chk("flush_calc_quiet", 64'(sticky), 64'd0);

        // Flush together with a request in IDLE must not accept it
        op = 2'd0; a = 32'd3; b = 32'd3; in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_block", 64'({in_ready, busy}), 64'b10);
        tick();
        chk("flush_idle_quiet", 64'({out_valid, busy}), 64'd0);

        // Flush in DONE discards the pending result
        start_op(2'd2, 1'b0, 1'b0, 32'd9, 32'd0);
        chk("done_pre_flush", 64'(out_valid), 64'd0);
        tick();
        chk("done_reached", 64'({out_valid, result}), 64'({1'b1, 32'hFFFF_FFFF}));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_done", 64'({in_ready, out_valid, busy, result}), 64'({3'b100, 32'h0}));

        // Reset pulse mid-CALC clears outputs immediately
        start_op(2'd1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678);
        for (int i = 0; i < 4; i++) tick();
        chk("busy_mid_calc", 64'({busy, in_ready}), 64'b10);
        #2;
        reset_n = 1'b0;
        #1;
        chk("reset_mid_calc", 64'({in_ready, out_valid, busy, result}), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        chk("ready_after_midreset", 64'({in_ready, busy, out_valid}), 64'b100);
        sticky = 1'b0;
        for (int i = 0; i < 20; i++) begin tick(); if (out_valid) sticky = 1'b1; end
        chk("midreset_quiet", 64'(sticky), 64'd0);

        // Randomised operands with stalls, checked against the model
        for (int i = 0; i < 40; i++) begin
            rv.op = 2'($urandom);
            rv.sa = 1'($urandom);
            rv.sb = 1'($urandom);
            rv.a  = $urandom;
            rv.b  = $urandom;
            case ($urandom_range(0, 9))
                0: rv.b = 32'h0;
                1: begin rv.a = 32'h8000_0000; rv.b = 32'hFFFF_FFFF; end
                2: rv.b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            rv.exp   = ref_res(rv.op, rv.sa, rv.sb, rv.a, rv.b);
            rv.lat   = ref_lat(rv.op, rv.sa, rv.a, rv.b);
            rv.stall = $urandom_range(0, 3);
            run_op(rv, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_24080006_mdu_iter.md
YSYX_24080006_MDU_ITER -- requirements
Module: ysyx_24080006_mdu_iter

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values 32 and 64.
REQ-002 SHALL have parameter STEP, default 2, bits retired per iteration cycle; legal 1, 2, 4; XLEN divisible by STEP.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; the ports are named clock and reset_n.
REQ-004 Ports, in order (name, direction, width, meaning):
- clock  in  1  rising-edge clock
- reset_n  in  1  async active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- op  in  2  mdu_op_e: MULL=0, MULH=1, DIV=2, REM=3
- signed_a  in  1  treat a as two's complement
- signed_b  in  1  treat b as two's complement
- a  in  XLEN  operand A / dividend
- b  in  XLEN  operand B / divisor
- flush  in  1  abandon current operation
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  result
- busy  out  1  state is not IDLE

Function
REQ-005 SHALL implement FSM states IDLE, CALC, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE; busy=1 in CALC or DONE.
REQ-006 Accept = in_valid && in_ready && !flush at a rising edge; op, signs, and operand magnitudes SHALL be latched; a and b SHALL be ignored afterwards.
REQ-007 On accept, state SHALL go to CALC with iteration counter = XLEN/STEP-1; each CALC cycle SHALL retire STEP bits; at counter==0 state SHALL go to DONE.
REQ-008 Normal latency: out_valid SHALL first be high XLEN/STEP+1 edges after the accept edge (XLEN=32, STEP=2: 17).
REQ-009 Multiply: SHALL compute the full 2*XLEN product of the sign-interpreted operands (MULH with signed_a=1 and signed_b=0 is MULHSU); MULL SHALL return the low XLEN bits, MULH the high XLEN bits.
REQ-010 Divide: DIV/REM signedness SHALL follow signed_a only; signed_b SHALL be ignored.
- Unsigned restoring algorithm on magnitudes, STEP quotient bits per cycle.
- Quotient negated iff operand signs differ; remainder takes the dividend's sign.
REQ-011 Divide by zero (b==0, op DIV/REM): SHALL skip CALC and enter DONE on the edge after accept (latency 1).
- DIV result: all ones.
- REM result: a.
REQ-012 Signed overflow (signed, a=-2^(XLEN-1), b=-1): SHALL skip CALC with latency 1.
- DIV result: a.
- REM result: 0.
REQ-013 In DONE, result SHALL be held stable while out_ready=0; on out_valid && out_ready, state SHALL return to IDLE on that edge.
REQ-014 No back-to-back accept from DONE: the earliest next accept SHALL be the cycle after the result handshake.
REQ-015 flush=1 SHALL force IDLE on the next edge from any state.
- Any pending result SHALL be discarded without out_valid.
- flush in IDLE SHALL block acceptance in the same cycle.
REQ-016 result SHALL read 0 whenever out_valid=0.

Reset
REQ-017 While reset_n=0, outputs SHALL be asynchronously forced to in_ready=0, out_valid=0, busy=0, result=0; state IDLE; counter 0.
REQ-018 After reset_n deasserts, in_ready SHALL be 1 from the first edge; reset mid-CALC or mid-DONE SHALL discard the operation with no out_valid.

Verification (XLEN=32, STEP=2)
REQ-019 MULL, signed, a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, out_valid 17 edges after accept; MULH signed 0x80000000*0x80000000 -> 0x40000000; MULH unsigned 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-020 DIV, signed, a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM, same operands -> 0xFFFFFFFF; DIV unsigned 100/7 -> 14; REM -> 2.
REQ-021 DIV, unsigned, a=5, b=0 -> 0xFFFFFFFF after 1 edge; REM -> 5; DIV signed 0x80000000/0xFFFFFFFF -> 0x80000000 after 1 edge; REM -> 0.
REQ-022 out_ready held 0 for 3 cycles in DONE -> result and out_valid stable; in_ready=0 throughout; IDLE after handshake.
REQ-023 flush at CALC cycle 5 -> IDLE next edge, no out_valid; flush with in_valid in IDLE -> no accept; reset_n pulse mid-CALC -> all outputs 0 immediately.
REQ-024 Random operands and ops vs a reference model, all sign combinations, out_ready randomly stalled -> exact match, latency 17 or 1 per REQ-008/011/012.
